cle_relabel: RTL and testbench

- Post-pass stage that runs directly downstream of the component labeling engine.
- Once labeling finishes, it scans the 32x32 label image held in the 1024x8 SRAM in raster order. It rewrites every non-zero label in place with a compact number: 1, 2, 3 … in order of first appearance.
- Background (0) pixels are left unwritten.
- Reports the object count and an overflow flag.

---
 rtl/cle_relabel_if.sv | 24 ++
 rtl/cle_relabel.sv | 136 +++++++++++++
 tb/tb_cle_relabel.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cle_relabel_if.sv
// SRAM port bundle between the relabel engine (master) and the 1024x8 label memory (slave).
// The memory is synchronous: address, write enable and data are sampled at the clock edge.
interface cle_relabel_if #(
  parameter int AW = 10
) ();
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_d;
  logic          sram_wen;
  logic [7:0]    sram_q;

  modport master (
    output sram_a,
    output sram_d,
    output sram_wen,
    input  sram_q
  );

  modport slave (
    input  sram_a,
    input  sram_d,
    input  sram_wen,
    output sram_q
  );
endinterface

// File: rtl/cle_relabel.sv
// Raster-order relabel pass: rewrites each non-zero label in place with a compact number
// assigned in order of first appearance, reporting object count and table overflow.
module cle_relabel #(
  parameter int MAX_LABELS = 16,
  parameter int AW         = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  cle_relabel_if.master        sram,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           obj_cnt,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         pix;
  logic [7:0]            tag [MAX_LABELS];
  logic [MAX_LABELS-1:0] tag_vld;

  logic       hit;
  logic [7:0] hit_idx;
  logic       full;
  logic       last;
  logic       alloc;
  logic       ovf_set;
  logic [7:0] wr_d;
  logic       wr_n;

  assign full = (obj_cnt == 8'(MAX_LABELS));
  assign last = (pix == {AW{1'b1}});

  assign sram.sram_a   = pix;
  assign sram.sram_d   = wr_d;
  assign sram.sram_wen = wr_n;

  // Parallel tag compare; entries fill in order, so the lowest hit is the only hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < MAX_LABELS; k++) begin
      if (!hit && tag_vld[k] && (tag[k] == sram.sram_q)) begin
        hit     = 1'b1;
        hit_idx = 8'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    wr_n    = 1'b1;
    wr_d    = '0;
    alloc   = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RD;
      end
      RD: begin
        busy    = 1'b1;
        state_d = WR;
      end
      WR: begin
        busy    = 1'b1;
        if (sram.sram_q != 8'h00) begin
          wr_n = 1'b0;
          if (hit) begin
            wr_d = hit_idx + 8'd1;
          end else if (!full) begin
            wr_d  = obj_cnt + 8'd1;
            alloc = 1'b1;
          end else begin
            wr_d    = 8'hFF;
            ovf_set = 1'b1;
          end
        end
        state_d = last ? FIN : RD;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pix      <= '0;
      obj_cnt  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      tag_vld  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            pix      <= '0;
            obj_cnt  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            tag_vld  <= '0;
          end
        end
        WR: begin
          if (alloc) begin
            obj_cnt <= obj_cnt + 8'd1;
            for (int k = 0; k < MAX_LABELS; k++) begin
              if (obj_cnt == 8'(k)) tag_vld[k] <= 1'b1;
            end
          end
          if (ovf_set) overflow <= 1'b1;
          // Hold at the last address; the scan terminates rather than wrapping.
          if (!last) pix <= pix + 1'b1;
        end
        FIN: begin
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag storage is qualified by tag_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_LABELS; k++) begin
      if (alloc && (obj_cnt == 8'(k))) tag[k] <= sram.sram_q;
    end
  end

endmodule

// File: tb/tb_cle_relabel.sv
// Bench for cle_relabel: SRAM model, first-appearance reference model and per-write checker.
module tb_cle_relabel;
  localparam int AW   = 10;
  localparam int N    = 1024;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, overflow;
  logic [7:0] obj_cnt;

  cle_relabel_if #(.AW(AW)) sif ();

  cle_relabel #(.MAX_LABELS(MAXL), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sram     (sif),
    .busy     (busy),
    .done     (done),
    .obj_cnt  (obj_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] mem    [N];
  logic [7:0] img    [N];
  logic [7:0] golden [N];
  logic [7:0] saved  [N];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) mem <= img;
    else if (!sif.sram_wen) mem[sif.sram_a] <= sif.sram_d;
    sif.sram_q <= mem[sif.sram_a];
  end

  typedef struct { int a; int d; } wr_t;
  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  wr_cnt = 0;
  bit  mon_en = 1'b0;
  int  m_cnt;
  bit  m_ovf;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // First-appearance numbering straight from the rules, using an associative map.
  task automatic build_model();
    int map [int];
    int v;
    int lab;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      lab = int'(img[i]);
      if (lab == 0) begin
        golden[i] = 8'h00;
      end else begin
        if (map.exists(lab)) v = map[lab];
        else if (m_cnt < MAXL) begin
          m_cnt++;
          map[lab] = m_cnt;
          v = m_cnt;
        end else begin
          v = 255;
          m_ovf = 1'b1;
        end
        golden[i] = 8'(v);
        exp_q.push_back('{i, v});
      end
    end
  endtask

  task automatic load_mem();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < N; i++) img[i] = 8'h00;
  endtask

  task automatic rand_img(input int pool);
    for (int i = 0; i < N; i++)
      img[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(256 - $urandom_range(1, pool));
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset && !sif.sram_wen) begin
        wr_cnt++;
        chk("wen low only while busy", int'(busy), 1);
        if (mon_en) begin
          if (exp_q.size() == 0) chk("unexpected write addr", int'(sif.sram_a), -1);
          else begin
            e = exp_q.pop_front();
            chk("write addr", int'(sif.sram_a), e.a);
            chk("write data", int'(sif.sram_d), e.d);
          end
        end
      end
    end
  endtask

  task automatic run_scan(input string nm, input bit hold);
    int n;
    wr_cnt = 0;
    mon_en = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " done latency"}, n, 2049);
    chk({nm, " busy after done"}, int'(busy), 0);
    chk({nm, " pending writes"}, exp_q.size(), 0);
  endtask

  task automatic check_result(input string nm);
    int errs;
    errs = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== golden[i]) errs++;
    chk({nm, " mem errors"}, errs, 0);
    chk({nm, " obj_cnt"}, int'(obj_cnt), m_cnt);
    chk({nm, " overflow"}, int'(overflow), int'(m_ovf));
  endtask

  initial begin
    int r0 [5];
    int c0 [5];
    logic [7:0] lb [5];
    reset = 1'b0;
    start = 1'b0;
    fork
      monitor();
    join_none

    #1;
    chk("rst sram_wen", int'(sif.sram_wen), 1);
    chk("rst sram_a", int'(sif.sram_a), 0);
    chk("rst sram_d", int'(sif.sram_d), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst obj_cnt", int'(obj_cnt), 0);
    chk("rst overflow", int'(overflow), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // All background: no writes at all.
    clear_img();
    load_mem();
    build_model();
    run_scan("zero", 1'b0);
    check_result("zero");
    chk("zero write cycles", wr_cnt, 0);
    chk("zero done held", int'(done), 1);

    // Sparse labels with a repeat.
    clear_img();
    img[0] = 8'h37; img[5] = 8'h05; img[40] = 8'h37;
    load_mem();
    build_model();
    run_scan("sparse", 1'b0);
    check_result("sparse");
    chk("sparse mem0", int'(mem[0]), 1);
    chk("sparse mem5", int'(mem[5]), 2);
    chk("sparse mem40", int'(mem[40]), 1);
    chk("sparse obj_cnt lit", int'(obj_cnt), 2);
    chk("sparse write cycles", wr_cnt, 3);

    // Five 4x4 blocks in a 32x32 image.
    r0 = '{0, 0, 8, 8, 16};
    c0 = '{0, 8, 0, 16, 4};
    lb = '{8'h20, 8'h09, 8'h20, 8'h41, 8'h09};
    clear_img();
    for (int b = 0; b < 5; b++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          img[(r0[b] + r) * 32 + c0[b] + c] = lb[b];
    load_mem();
    build_model();
    run_scan("blocks", 1'b0);
    check_result("blocks");
    chk("blocks b0", int'(mem[0]), 1);
    chk("blocks b1", int'(mem[8]), 2);
    chk("blocks b2", int'(mem[8 * 32]), 1);
    chk("blocks b3", int'(mem[8 * 32 + 16 + 3 * 32 + 3]), 3);
    chk("blocks b4", int'(mem[16 * 32 + 4]), 2);
    chk("blocks obj_cnt lit", int'(obj_cnt), 3);

    // Seventeen distinct labels overflow a 16-entry table.
    clear_img();
    for (int i = 0; i < 17; i++) img[i] = 8'(i + 1);
    load_mem();
    build_model();
    run_scan("ovf", 1'b0);
    check_result("ovf");
    chk("ovf mem15", int'(mem[15]), 16);
    chk("ovf mem16", int'(mem[16]), 255);
    chk("ovf flag lit", int'(overflow), 1);
    chk("ovf obj_cnt lit", int'(obj_cnt), 16);

    // Random images: small pools (includes label 0xFF) and a wide pool that overflows.
    rand_img(12);  load_mem(); build_model(); run_scan("rand12", 1'b0);  check_result("rand12");
    rand_img(6);   load_mem(); build_model(); run_scan("rand6", 1'b0);   check_result("rand6");
    rand_img(255); load_mem(); build_model(); run_scan("rand255", 1'b0); check_result("rand255");

    // Asynchronous reset during the write cycle of pixel 300, then a full rescan.
    rand_img(8);
    img[300] = 8'h33;
    load_mem();
    mon_en = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (601) @(posedge clk);
    #1;
    chk("abort addr at WR", int'(sif.sram_a), 300);
    chk("abort wen before reset", int'(sif.sram_wen), 0);
    reset = 1'b0;
    #1;
    chk("abort wen", int'(sif.sram_wen), 1);
    chk("abort busy", int'(busy), 0);
    chk("abort obj_cnt", int'(obj_cnt), 0);
    chk("abort sram_a", int'(sif.sram_a), 0);
    @(negedge clk) reset = 1'b1;
    load_mem();
    build_model();
    run_scan("rescan", 1'b0);
    check_result("rescan");

    // Start held high: exactly one scan, then a second idempotent scan from IDLE.
    rand_img(10);
    load_mem();
    build_model();
    run_scan("held1", 1'b1);
    chk("held1 done in idle", int'(done), 1);
    check_result("held1");
    saved = golden;
    img = mem;
    build_model();
    run_scan("held2", 1'b1);
    start = 1'b0;
    check_result("held2");
    begin
      int errs;
      errs = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== saved[i]) errs++;
      chk("held2 unchanged", errs, 0);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
